// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: loader state encoding and the RAM
// access-size code also used by basic_ram and the ARMv4 core.
package boot_pkg;

    localparam logic [2:0] LOAD_WAIT  = 3'd0;
    localparam logic [2:0] LOAD_WRITE = 3'd1;
    localparam logic [2:0] LOAD_GAP   = 3'd2;
    localparam logic [2:0] DONE       = 3'd3;
    localparam logic [2:0] ERR        = 3'd4;

    localparam logic [1:0] DATA_SIZE_WORD = 2'b11;

    // Byte address of image word idx; 32-bit arithmetic wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/ram_bus_mux.sv
// Routes either the loader's write port or the core's memory port onto the
// basic_ram bus; the core only sees ram_ready once it owns the bus.
module ram_bus_mux
    import boot_pkg::*;
(
    input  logic        sel,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic        ld_cs,
    input  logic        ld_we,
    input  logic        ld_oe,
    input  logic [1:0]  ld_data_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_cs,
    input  logic        core_we,
    input  logic        core_oe,
    input  logic [1:0]  core_data_size,
    input  logic        ram_ready,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        ram_oe,
    output logic [1:0]  ram_data_size,
    output logic        core_ready
);

    always_comb begin
        ram_addr      = ld_addr;
        ram_wdata     = ld_wdata;
        ram_cs        = ld_cs;
        ram_we        = ld_we;
        ram_oe        = ld_oe;
        ram_data_size = ld_data_size;
        core_ready    = 1'b0;
        if (sel) begin
            ram_addr      = core_addr;
            ram_wdata     = core_wdata;
            ram_cs        = core_cs;
            ram_we        = core_we;
            ram_oe        = core_oe;
            ram_data_size = core_data_size;
            core_ready    = ram_ready;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into basic_ram while holding the ARMv4 core in reset,
// then hands the RAM bus to the core and releases it.
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096,
    parameter int          TIMEOUT   = 1023,
    localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic [31:0]   core_addr,
    input  logic [31:0]   core_wdata,
    input  logic          core_cs,
    input  logic          core_we,
    input  logic          core_oe,
    input  logic [1:0]    core_data_size,
    output logic [31:0]   core_rdata,
    output logic          core_ready,
    output logic          core_rst,
    output logic [31:0]   ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [1:0]    ram_data_size,
    input  logic [31:0]   ram_rdata,
    input  logic          ram_ready,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] word_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [2:0]    state_reg;
    logic [CW-1:0] word_count_reg;
    logic [TW-1:0] wait_cnt_reg;
    logic          last_reg;
    logic          ld_cs_reg;
    logic          ld_we_reg;
    logic [31:0]   ld_addr_reg;
    logic [31:0]   ld_wdata_reg;
    logic          done_reg;
    logic          err_reg;
    logic          core_rst_reg;

    assign s_ready    = (state_reg == LOAD_WAIT);
    assign core_rdata = ram_rdata;
    assign core_rst   = core_rst_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign word_count = word_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LOAD_WAIT;
            word_count_reg <= '0;
            wait_cnt_reg   <= '0;
            last_reg       <= 1'b0;
            ld_cs_reg      <= 1'b0;
            ld_we_reg      <= 1'b0;
            ld_addr_reg    <= BASE_ADDR;
            ld_wdata_reg   <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            core_rst_reg   <= 1'b1;
        end else begin
            case (state_reg)
                LOAD_WAIT: begin
                    if (s_valid && s_ready) begin
                        ld_wdata_reg <= s_data;
                        last_reg     <= s_last;
                        ld_addr_reg  <= word_addr(BASE_ADDR, 32'(word_count_reg));
                        ld_cs_reg    <= 1'b1;
                        ld_we_reg    <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= LOAD_WRITE;
                    end
                end
                LOAD_WRITE: begin
                    if (ram_ready) begin
                        word_count_reg <= word_count_reg + 1'b1;
                        ld_cs_reg      <= 1'b0;
                        ld_we_reg      <= 1'b0;
                        state_reg      <= LOAD_GAP;
                    end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                        // TIMEOUT cycles spent in this write without completion.
                        ld_cs_reg <= 1'b0;
                        ld_we_reg <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                LOAD_GAP: begin
                    if (last_reg || (word_count_reg == CW'(MAX_WORDS))) begin
                        done_reg     <= 1'b1;
                        core_rst_reg <= 1'b0;
                        state_reg    <= DONE;
                    end else begin
                        state_reg <= LOAD_WAIT;
                    end
                end
                DONE: state_reg <= DONE;
                ERR:  state_reg <= ERR;
                default: begin
                    ld_cs_reg <= 1'b0;
                    ld_we_reg <= 1'b0;
                    err_reg   <= 1'b1;
                    state_reg <= ERR;
                end
            endcase
        end
    end

    ram_bus_mux u_mux (
        .sel            (state_reg == DONE),
        .ld_addr        (ld_addr_reg),
        .ld_wdata       (ld_wdata_reg),
        .ld_cs          (ld_cs_reg),
        .ld_we          (ld_we_reg),
        .ld_oe          (1'b0),
        .ld_data_size   (DATA_SIZE_WORD),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_cs        (core_cs),
        .core_we        (core_we),
        .core_oe        (core_oe),
        .core_data_size (core_data_size),
        .ram_ready      (ram_ready),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_oe         (ram_oe),
        .ram_data_size  (ram_data_size),
        .core_ready     (core_ready)
    );

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: accepted stream words queue expected RAM
// writes, a bus monitor queues the writes the RAM actually sees.
module tb_boot_loader;

    localparam int MAXW = 4;
    localparam int TMO  = 15;
    localparam int CW   = $clog2(MAXW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [31:0]   core_addr = '0;
    logic [31:0]   core_wdata = '0;
    logic          core_cs = 1'b0;
    logic          core_we = 1'b0;
    logic          core_oe = 1'b0;
    logic [1:0]    core_data_size = 2'b11;
    logic [31:0]   core_rdata;
    logic          core_ready;
    logic          core_rst;
    logic [31:0]   ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    logic [1:0]    ram_data_size;
    logic [31:0]   ram_rdata;
    logic          ram_ready;
    logic          done;
    logic          err;
    logic [CW-1:0] word_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_cs(core_cs),
        .core_we(core_we), .core_oe(core_oe), .core_data_size(core_data_size),
        .core_rdata(core_rdata), .core_ready(core_ready), .core_rst(core_rst),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_oe(ram_oe), .ram_data_size(ram_data_size), .ram_rdata(ram_rdata),
        .ram_ready(ram_ready), .done(done), .err(err), .word_count(word_count)
    );

    // RAM model: mode 0 answers 2 cycles after cs, mode 1 never answers, mode 2 always ready.
    logic [31:0] mem [0:15];
    int          ram_mode = 0;
    logic        rdy_reg = 1'b0;
    int          rcnt = 0;

    assign ram_ready = (ram_mode == 2) ? 1'b1 : ((ram_mode == 1) ? 1'b0 : rdy_reg);
    assign ram_rdata = mem[ram_addr[5:2]];

    always @(posedge clk) begin
        if (ram_mode == 0 && ram_cs && !rdy_reg) begin
            if (rcnt == 1) begin
                rdy_reg <= 1'b1;
                rcnt    <= 0;
            end else begin
                rcnt <= rcnt + 1;
            end
        end else begin
            rdy_reg <= 1'b0;
            rcnt    <= 0;
        end
        if (ram_cs && ram_we && ram_ready)
            mem[ram_addr[5:2]] <= ram_wdata;
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   hi_q[$];
    int   lo_q[$];
    int   hi_run = 0;
    int   lo_run = 0;
    logic prev_cs = 1'b0;
    bit   seen_write = 1'b0;
    int   ready_leak = 0;

    // Bus monitor, sampled on the falling edge while the loader owns the bus.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !done) begin
                if (core_ready) ready_leak++;
                if (ram_cs) begin
                    if (!prev_cs && seen_write) lo_q.push_back(lo_run);
                    hi_run++;
                    if (ram_we && ram_ready) begin
                        obs_q.push_back({ram_addr, ram_wdata, ram_data_size});
                        seen_write = 1'b1;
                        $display("write addr=%08h data=%08h size=%b", ram_addr, ram_wdata, ram_data_size);
                    end
                end else begin
                    if (prev_cs) begin
                        hi_q.push_back(hi_run);
                        hi_run = 0;
                        lo_run = 0;
                    end
                    lo_run++;
                end
                prev_cs = ram_cs;
            end
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        hi_q.delete();
        lo_q.delete();
        hi_run = 0;
        lo_run = 0;
        prev_cs = 1'b0;
        seen_write = 1'b0;
        ready_leak = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
    endtask

    // Offers one word until accepted or the budget runs out; acceptance happens at the next posedge.
    task automatic drive_word(input logic [31:0] d, input logic last, input int budget, output bit acc);
        acc = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data = d;
            s_last = last;
            if (s_ready) begin
                acc = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_stream();
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = $urandom;
    endtask

    task automatic wait_end(input int budget, output bit ok, output int rst_mism);
        ok = 1'b0;
        rst_mism = 0;
        for (int c = 0; c < budget; c++) begin
            if (done !== ~core_rst) rst_mism++;
            if (done || err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({done, err, core_rst} !== 3'b001) begin
            n_fail++; $display("FAIL reset_flags: done/err/core_rst=%b expected 001", {done, err, core_rst});
        end
        n_checks++;
        if ({ram_cs, ram_we, ram_oe, ram_data_size} !== 5'b00011) begin
            n_fail++; $display("FAIL reset_bus: cs/we/oe/size=%b expected 00011", {ram_cs, ram_we, ram_oe, ram_data_size});
        end
        n_checks++;
        if (ram_addr !== 32'h0 || word_count !== '0) begin
            n_fail++; $display("FAIL reset_addr_count: addr=%h count=%0d expected 0/0", ram_addr, word_count);
        end
        n_checks++;
        if (s_ready !== 1'b1 || core_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: s_ready=%b core_ready=%b expected 1/0", s_ready, core_ready);
        end
    endtask

    task automatic test_three_word();
        logic [31:0] img [3];
        bit acc, ok;
        int mism;
        wr_t e, o;
        img[0] = 32'hE3A00001; img[1] = 32'hE2800002; img[2] = 32'hEAFFFFFE;
        ram_mode = 0;
        // Core tries to read during the load; it must be ignored.
        core_cs = 1'b1; core_oe = 1'b1; core_we = 1'b0; core_addr = 32'h20;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_word(img[i], (i == 2), 50, acc);
            n_checks++;
            if (!acc) begin n_fail++; $display("FAIL three_accept: word %0d not accepted expected accepted", i); end
            else exp_q.push_back({32'(i * 4), img[i], 2'b11});
        end
        idle_stream();
        wait_end(100, ok, mism);
        n_checks++;
        if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL three_done: done=%b expected 1", done); end
        n_checks++;
        if (mism != 0 || core_rst !== 1'b0) begin
            n_fail++; $display("FAIL three_done_rst_edge: %0d cycles done==core_rst, core_rst=%b expected 0/0", mism, core_rst);
        end
        n_checks++;
        if (word_count !== CW'(3)) begin n_fail++; $display("FAIL three_count: got %0d expected 3", word_count); end
        n_checks++;
        if (obs_q.size() != 3) begin n_fail++; $display("FAIL three_nwrites: got %0d expected 3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL three_write: got %h/%h/%b expected %h/%h/%b", o.a, o.d, o.sz, e.a, e.d, e.sz); end
        end
        // Low time between writes is the GAP cycle plus the LOAD_WAIT accept cycle.
        n_checks++;
        if (lo_q.size() != 2 || lo_q[0] != 2 || lo_q[1] != 2) begin
            n_fail++; $display("FAIL three_gap: %0d gaps, first=%0d expected 2 gaps of 2", lo_q.size(), (lo_q.size() > 0) ? lo_q[0] : -1);
        end
        n_checks++;
        if (ready_leak != 0) begin n_fail++; $display("FAIL three_core_ready_leak: %0d cycles expected 0", ready_leak); end
    endtask

    task automatic test_core_read();
        int mism = 0;
        bit saw = 1'b0;
        @(negedge clk);
        core_cs = 1'b0; core_oe = 1'b0;
        @(negedge clk);
        core_addr = 32'h8; core_cs = 1'b1; core_oe = 1'b1; core_we = 1'b0;
        #1;
        n_checks++;
        if (ram_addr !== 32'h8 || ram_cs !== 1'b1 || ram_oe !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL read_bus: addr=%h cs/oe/we=%b expected 00000008/110", ram_addr, {ram_cs, ram_oe, ram_we});
        end
        n_checks++;
        if (core_rdata !== 32'hEAFFFFFE) begin n_fail++; $display("FAIL read_data: got %h expected eafffffe", core_rdata); end
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL done_s_ready: got %b expected 0", s_ready); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (core_ready !== ram_ready) mism++;
            if (ram_ready) saw = 1'b1;
        end
        n_checks++;
        if (mism != 0 || !saw) begin n_fail++; $display("FAIL read_ready: %0d mismatches, ready seen=%b expected 0/1", mism, saw); end
        @(negedge clk);
        core_cs = 1'b0; core_oe = 1'b0;
    endtask

    task automatic test_max_words();
        bit acc, ok;
        int mism;
        wr_t e, o;
        logic [31:0] d;
        ram_mode = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            drive_word(d, 1'b0, 40, acc);
            n_checks++;
            if (acc !== (i < MAXW)) begin n_fail++; $display("FAIL max_accept: word %0d accepted=%b expected %b", i, acc, (i < MAXW)); end
            if (acc) exp_q.push_back({32'(i * 4), d, 2'b11});
        end
        idle_stream();
        wait_end(20, ok, mism);
        n_checks++;
        if (!ok || done !== 1'b1 || word_count !== CW'(MAXW)) begin
            n_fail++; $display("FAIL max_done: done=%b count=%0d expected 1/%0d", done, word_count, MAXW);
        end
        n_checks++;
        if (obs_q.size() != MAXW) begin n_fail++; $display("FAIL max_nwrites: got %0d expected %0d", obs_q.size(), MAXW); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL max_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_timeout();
        bit acc, ok;
        int mism;
        ram_mode = 1;
        do_reset();
        drive_word(32'h1234_5678, 1'b1, 10, acc);
        idle_stream();
        wait_end(100, ok, mism);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL timeout_err: err=%b done=%b expected 1/0", err, done); end
        n_checks++;
        if (hi_q.size() != 1 || hi_q[0] != TMO) begin
            n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", (hi_q.size() > 0) ? hi_q[0] : -1, TMO);
        end
        n_checks++;
        if (core_rst !== 1'b1 || ram_cs !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL timeout_outputs: core_rst/ram_cs/s_ready=%b expected 100", {core_rst, ram_cs, s_ready});
        end
        ram_mode = 0;
    endtask

    task automatic test_reset_mid_write();
        bit acc, ok;
        int mism;
        wr_t e, o;
        logic [31:0] img [3];
        img[0] = 32'hA0A0_0001; img[1] = 32'hB0B0_0002; img[2] = 32'hC0C0_0003;
        ram_mode = 0;
        do_reset();
        drive_word(32'h1111_1111, 1'b0, 20, acc);
        drive_word(32'h2222_2222, 1'b0, 20, acc);
        @(negedge clk);
        n_checks++;
        if (ram_cs !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: ram_cs=%b expected 1", ram_cs); end
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ram_cs !== 1'b0 || word_count !== '0) begin
            n_fail++; $display("FAIL midrst_state: ram_cs=%b count=%0d expected 0/0", ram_cs, word_count);
        end
        rst = 1'b0;
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            drive_word(img[i], (i == 2), 50, acc);
            if (acc) exp_q.push_back({32'(i * 4), img[i], 2'b11});
        end
        idle_stream();
        wait_end(100, ok, mism);
        n_checks++;
        if (!ok || done !== 1'b1 || obs_q.size() != 3) begin
            n_fail++; $display("FAIL midrst_reload: done=%b writes=%0d expected 1/3", done, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_ready_high();
        bit acc, ok;
        int mism;
        wr_t e, o;
        ram_mode = 2;
        do_reset();
        drive_word(32'h0BAD_F00D, 1'b0, 20, acc);
        if (acc) exp_q.push_back({32'h0, 32'h0BAD_F00D, 2'b11});
        drive_word(32'hFEED_FACE, 1'b1, 20, acc);
        if (acc) exp_q.push_back({32'h4, 32'hFEED_FACE, 2'b11});
        idle_stream();
        wait_end(30, ok, mism);
        n_checks++;
        if (!ok || done !== 1'b1 || hi_q.size() != 2 || hi_q[0] != 1 || hi_q[1] != 1) begin
            n_fail++; $display("FAIL ready_high_cycles: done=%b writes=%0d first len=%0d expected 1/2/1",
                               done, hi_q.size(), (hi_q.size() > 0) ? hi_q[0] : -1);
        end
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL ready_high_nwrites: got %0d expected 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ready_high_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
        ram_mode = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int mism;
        int idx = 0;
        wr_t e, o;
        ram_mode = 0;
        do_reset();
        // s_valid toggles every cycle and s_data changes every cycle, including during writes.
        for (int c = 0; c < 200 && idx < 3; c++) begin
            @(negedge clk);
            s_valid = c[0];
            s_data = $urandom;
            s_last = (idx == 2);
            if (s_valid && s_ready) begin
                exp_q.push_back({32'(idx * 4), s_data, 2'b11});
                idx++;
            end
        end
        idle_stream();
        wait_end(100, ok, mism);
        n_checks++;
        if (!ok || done !== 1'b1 || obs_q.size() != 3) begin
            n_fail++; $display("FAIL toggle_done: done=%b writes=%0d expected 1/3", done, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL toggle_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_three_word();
        test_core_read();
        test_max_words();
        test_timeout();
        test_reset_mid_write();
        test_ready_high();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
